// File: rtl/i2c_follower_eeprom.sv
// i2c_follower_eeprom
// I2C follower that fronts a 512x8 memory, in the style of a small serial
// EEPROM. The leader selects the device with a 7-bit address, then writes a
// two-byte word address (only bit 0 of the high byte is kept) followed by
// data bytes, or reads sequentially from the current pointer.
//
// Ports:
//   CLK_50MHz  system clock, rising-edge
//   RESET      asynchronous, active-low reset
//   SCL        I2C clock from the leader
//   SDA        open-drain data, only ever pulled low or released
//   WP         write protect, 1 blocks memory writes and NACKs data bytes
//   BUSY       high while this device is addressed
//   DBG_ADDR   backdoor read address
//   DBG_DATA   mem[DBG_ADDR], combinational
module i2c_follower_eeprom #(
   parameter logic [6:0] DEV_ADDR  = 7'b1010000,
   parameter int         PAGE_BITS = 4
) (
   input  logic       CLK_50MHz,
   input  logic       RESET,
   input  logic       SCL,
   inout  wire        SDA,
   input  logic       WP,
   output logic       BUSY,
   input  logic [8:0] DBG_ADDR,
   output logic [7:0] DBG_DATA
);

   typedef enum logic [3:0] {
      IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WDATA, ACK_W, RDATA, RACK
   } state_t;

   localparam logic [8:0] PAGE_MASK = 9'((1 << PAGE_BITS) - 1);

   state_t     state, state_nxt;
   logic       scl_meta, scl_sync, scl_prev;
   logic       sda_meta, sda_sync, sda_prev;
   logic [3:0] bit_cnt;
   logic [7:0] shift_reg;
   logic [7:0] tx_byte;
   logic [8:0] ptr;
   logic [8:0] ptr_page_inc;
   logic       rw;
   logic       ahi0;
   logic       ack_w;
   logic       sda_drive_low;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic       bit_done, addr_match, mem_we;
   logic [7:0] mem [0:511];

   // Synchronizers idle high so that reset never manufactures an edge.
   always_ff @(posedge CLK_50MHz or negedge RESET) begin
      if (!RESET) begin
         scl_meta <= 1'b1;
         scl_sync <= 1'b1;
         scl_prev <= 1'b1;
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_meta <= SCL;
         scl_sync <= scl_meta;
         scl_prev <= scl_sync;
         sda_meta <= SDA;
         sda_sync <= sda_meta;
         sda_prev <= sda_sync;
      end
   end

   assign scl_rise   = scl_sync & ~scl_prev;
   assign scl_fall   = ~scl_sync & scl_prev;
   assign start_det  = scl_sync & scl_prev & sda_prev & ~sda_sync;
   assign stop_det   = scl_sync & scl_prev & ~sda_prev & sda_sync;
   assign bit_done   = (bit_cnt == 4'd8);
   assign addr_match = (shift_reg[7:1] == DEV_ADDR);
   assign mem_we     = (state == WDATA) && scl_rise && (bit_cnt == 4'd7) && !WP;

   // Writes advance only the low PAGE_BITS of the pointer, wrapping in the page.
   assign ptr_page_inc = (ptr & ~PAGE_MASK) | ((ptr + 9'd1) & PAGE_MASK);

   always_ff @(posedge CLK_50MHz or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // Byte states leave on the SCL fall after the 8th bit, acknowledge states
   // on the very next SCL fall, so every ack slot is exactly one SCL period.
   always_comb begin
      state_nxt = state;
      if (start_det) begin
         state_nxt = DEV;
      end else if (stop_det) begin
         state_nxt = IDLE;
      end else if (scl_fall) begin
         unique case (state)
            IDLE:    state_nxt = IDLE;
            DEV:     if (bit_done) state_nxt = addr_match ? ACK_DEV : IDLE;
            ACK_DEV: state_nxt = rw ? RDATA : AHI;
            AHI:     if (bit_done) state_nxt = ACK_AHI;
            ACK_AHI: state_nxt = ALO;
            ALO:     if (bit_done) state_nxt = ACK_ALO;
            ACK_ALO: state_nxt = WDATA;
            WDATA:   if (bit_done) state_nxt = ACK_W;
            ACK_W:   state_nxt = WDATA;
            RDATA:   if (bit_done) state_nxt = RACK;
            RACK:    state_nxt = shift_reg[0] ? IDLE : RDATA;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      sda_drive_low = 1'b0;
      unique case (state)
         ACK_DEV, ACK_AHI, ACK_ALO: sda_drive_low = 1'b1;
         ACK_W:                     sda_drive_low = ack_w;
         RDATA:                     sda_drive_low = ~tx_byte[7];
         default:                   sda_drive_low = 1'b0;
      endcase
   end

   // Gating with RESET releases the line immediately, without waiting for the
   // state register to settle.
   assign SDA = (sda_drive_low && RESET) ? 1'b0 : 1'bz;

   // Bit counting, shifting, pointer and BUSY bookkeeping. The shift register
   // also catches the leader's ack bit, so RACK reads it from bit 0.
   always_ff @(posedge CLK_50MHz or negedge RESET) begin
      if (!RESET) begin
         bit_cnt   <= 4'd0;
         shift_reg <= 8'd0;
         tx_byte   <= 8'hFF;
         ptr       <= 9'd0;
         rw        <= 1'b0;
         ahi0      <= 1'b0;
         ack_w     <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         if (start_det || state == IDLE || state != state_nxt)
            bit_cnt <= 4'd0;
         else if (scl_rise && !bit_done)
            bit_cnt <= bit_cnt + 4'd1;

         if (scl_rise)
            shift_reg <= {shift_reg[6:0], sda_sync};

         if (state == DEV && scl_fall && bit_done)
            rw <= shift_reg[0];
         if (state == AHI && scl_fall && bit_done)
            ahi0 <= shift_reg[0];
         if (state == ALO && scl_fall && bit_done)
            ptr <= {ahi0, shift_reg};

         if (state == WDATA && scl_rise && bit_cnt == 4'd7) begin
            ack_w <= !WP;
            if (!WP)
               ptr <= ptr_page_inc;
         end

         if (state == ACK_DEV && scl_fall && rw)
            tx_byte <= mem[ptr];
         if (state == RDATA && scl_fall && !bit_done)
            tx_byte <= {tx_byte[6:0], 1'b1};
         if (state == RACK && scl_fall) begin
            ptr <= ptr + 9'd1;
            if (!shift_reg[0])
               tx_byte <= mem[ptr + 9'd1];
         end

         if (start_det || stop_det)
            BUSY <= 1'b0;
         else if (state == ACK_DEV)
            BUSY <= 1'b1;
         else if (state == DEV && scl_fall && bit_done && !addr_match)
            BUSY <= 1'b0;
      end
   end

   // Memory has no reset; a partial byte never reaches it because the write
   // strobe needs the 8th SCL rise.
   always_ff @(posedge CLK_50MHz) begin
      if (mem_we)
         mem[ptr] <= {shift_reg[6:0], sda_sync};
   end

   assign DBG_DATA = mem[DBG_ADDR];

endmodule

// File: tb/tb_i2c_follower_eeprom.sv
// tb_i2c_follower_eeprom
// Bench for i2c_follower_eeprom: a bit-banged I2C leader on an open-drain
// bus with a pull-up. Expected values go into a scoreboard queue as stimulus
// is driven and are popped when the matching bus or backdoor value is seen.
`timescale 1ns/1ps
module tb_i2c_follower_eeprom;

   localparam int HALF = 5;
   localparam int Q    = 10;

   logic       clk;
   logic       reset_n;
   logic       scl;
   logic       sda_low;
   logic       wp;
   logic       busy;
   logic [8:0] dbg_addr;
   logic [7:0] dbg_data;
   wire        sda_bus;

   assign sda_bus = sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_follower_eeprom dut (
      .CLK_50MHz (clk),
      .RESET     (reset_n),
      .SCL       (scl),
      .SDA       (sda_bus),
      .WP        (wp),
      .BUSY      (busy),
      .DBG_ADDR  (dbg_addr),
      .DBG_DATA  (dbg_data)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [8:0] addr;
      logic [6:0] hi_pad;
      logic [7:0] data;
      bit         wp;
      logic [7:0] exp_mem;
   } vec_t;

   vec_t       vecs [7];
   string      tag_q [$];
   logic [7:0] exp_q [$];
   int         tests = 0;
   int         fails = 0;
   bit         watch = 0;
   bit         saw_low = 0;
   bit         saw_busy = 0;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Flags any low level on the bus the leader is not responsible for.
   initial forever begin
      @(negedge clk);
      #2;
      if (watch) begin
         if (sda_bus === 1'b0 && !sda_low) saw_low = 1;
         if (busy) saw_busy = 1;
      end
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushExp(input string tag, input logic [7:0] exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic checkOutput(input logic [7:0] actual);
      string      tag;
      logic [7:0] exp;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("[TB] FAIL scoreboard: got %0h with nothing expected", actual);
      end else begin
         tag = tag_q.pop_front();
         exp = exp_q.pop_front();
         if (actual !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, exp);
         end
      end
   endtask

   task automatic busStart();
      if (scl) begin
         sda_low = 0;
         waitClk(HALF);
      end else begin
         waitClk(HALF);
         sda_low = 0;
         waitClk(HALF);
         scl = 1;
         waitClk(HALF);
      end
      sda_low = 1;
      waitClk(Q);
      scl = 0;
   endtask

   task automatic busStop();
      waitClk(HALF);
      sda_low = 1;
      waitClk(HALF);
      scl = 1;
      waitClk(Q);
      sda_low = 0;
      waitClk(Q);
   endtask

   task automatic writeBit(input bit b);
      waitClk(HALF);
      sda_low = ~b;
      waitClk(HALF);
      scl = 1;
      waitClk(Q);
      scl = 0;
   endtask

   task automatic readBit(output bit b);
      waitClk(HALF);
      sda_low = 0;
      waitClk(HALF);
      scl = 1;
      waitClk(HALF);
      b = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
      waitClk(HALF);
      scl = 0;
   endtask

   task automatic sendByte(input logic [7:0] val, input string tag, input bit exp_ack);
      bit a;
      pushExp(tag, {7'd0, exp_ack});
      for (int i = 7; i >= 0; i--) writeBit(val[i]);
      readBit(a);
      checkOutput({7'd0, a});
   endtask

   task automatic recvByte(input logic [7:0] exp, input string tag, input bit ack);
      logic [7:0] got;
      bit         b;
      pushExp(tag, exp);
      for (int i = 7; i >= 0; i--) begin
         readBit(b);
         got[i] = b;
      end
      writeBit(ack);
      checkOutput(got);
   endtask

   task automatic checkMem(input logic [8:0] addr, input logic [7:0] exp, input string tag);
      pushExp(tag, exp);
      dbg_addr = addr;
      #1;
      checkOutput(dbg_data);
   endtask

   task automatic checkBusy(input bit exp, input string tag);
      pushExp(tag, {7'd0, exp});
      #1;
      checkOutput({7'd0, busy});
   endtask

   // One table entry: single-byte write, backdoor check, random read back.
   task automatic applyStimulus(input vec_t v);
      wp = v.wp;
      busStart();
      sendByte(8'hA0, "dev ack", 1'b0);
      checkBusy(1'b1, "busy after dev ack");
      sendByte({v.hi_pad, v.addr[8]}, "ahi ack", 1'b0);
      sendByte(v.addr[7:0], "alo ack", 1'b0);
      sendByte(v.data, "data ack", v.wp);
      busStop();
      checkBusy(1'b0, "busy after stop");
      wp = 0;
      checkMem(v.addr, v.exp_mem, "backdoor");
      busStart();
      sendByte(8'hA0, "rd dev ack", 1'b0);
      sendByte({v.hi_pad, v.addr[8]}, "rd ahi ack", 1'b0);
      sendByte(v.addr[7:0], "rd alo ack", 1'b0);
      busStart();
      sendByte(8'hA1, "rd dev read ack", 1'b0);
      recvByte(v.exp_mem, "read back", 1'b1);
      busStop();
   endtask

   initial begin
      vecs[0] = '{addr: 9'h006, hi_pad: 7'h00, data: 8'h66, wp: 1'b0, exp_mem: 8'h66};
      vecs[1] = '{addr: 9'h005, hi_pad: 7'h00, data: 8'h3C, wp: 1'b0, exp_mem: 8'h3C};
      vecs[2] = '{addr: 9'h010, hi_pad: 7'h55, data: 8'h77, wp: 1'b0, exp_mem: 8'h77};
      vecs[3] = '{addr: 9'h1A5, hi_pad: 7'h2A, data: 8'h99, wp: 1'b0, exp_mem: 8'h99};
      vecs[4] = '{addr: 9'h1FF, hi_pad: 7'h00, data: 8'hAB, wp: 1'b0, exp_mem: 8'hAB};
      vecs[5] = '{addr: 9'h0C3, hi_pad: 7'h7F, data: 8'h00, wp: 1'b0, exp_mem: 8'h00};
      vecs[6] = '{addr: 9'h005, hi_pad: 7'h00, data: 8'h5A, wp: 1'b1, exp_mem: 8'h3C};

      reset_n  = 0;
      scl      = 1;
      sda_low  = 0;
      wp       = 0;
      dbg_addr = '0;
      waitClk(5);
      checkBusy(1'b0, "busy in reset");
      pushExp("sda in reset", 8'd1);
      checkOutput({7'd0, (sda_bus === 1'b0) ? 1'b0 : 1'b1});
      reset_n = 1;
      waitClk(5);

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      $display("[TB] random read then current-address read");
      busStart();
      sendByte(8'hA0, "rs dev ack", 1'b0);
      sendByte(8'h00, "rs ahi ack", 1'b0);
      sendByte(8'h05, "rs alo ack", 1'b0);
      busStart();
      sendByte(8'hA1, "rs read ack", 1'b0);
      recvByte(8'h3C, "rs byte", 1'b1);
      busStop();
      busStart();
      sendByte(8'hA1, "cur read ack", 1'b0);
      recvByte(8'h66, "ptr after read", 1'b1);
      busStop();

      $display("[TB] page wrap write");
      busStart();
      sendByte(8'hA0, "pg dev ack", 1'b0);
      sendByte(8'h00, "pg ahi ack", 1'b0);
      sendByte(8'h0E, "pg alo ack", 1'b0);
      sendByte(8'h11, "pg d0 ack", 1'b0);
      sendByte(8'h22, "pg d1 ack", 1'b0);
      sendByte(8'h33, "pg d2 ack", 1'b0);
      busStop();
      checkMem(9'h00E, 8'h11, "mem 0x0E");
      checkMem(9'h00F, 8'h22, "mem 0x0F");
      checkMem(9'h000, 8'h33, "mem 0x00");
      checkMem(9'h010, 8'h77, "mem 0x10");

      $display("[TB] sequential read across 511");
      busStart();
      sendByte(8'hA0, "wr dev ack", 1'b0);
      sendByte(8'h01, "wr ahi ack", 1'b0);
      sendByte(8'hFF, "wr alo ack", 1'b0);
      busStart();
      sendByte(8'hA1, "wr read ack", 1'b0);
      recvByte(8'hAB, "byte 0x1FF", 1'b0);
      recvByte(8'h33, "byte after wrap", 1'b1);
      busStop();

      $display("[TB] foreign address");
      saw_low  = 0;
      saw_busy = 0;
      watch    = 1;
      busStart();
      sendByte(8'hA2, "foreign nack", 1'b1);
      sendByte(8'h00, "ignored byte", 1'b1);
      busStop();
      watch = 0;
      pushExp("sda low on foreign", 8'd0);
      checkOutput({7'd0, saw_low});
      pushExp("busy on foreign", 8'd0);
      checkOutput({7'd0, saw_busy});

      $display("[TB] reset during read");
      busStart();
      sendByte(8'hA0, "rr dev ack", 1'b0);
      sendByte(8'h00, "rr ahi ack", 1'b0);
      sendByte(8'h05, "rr alo ack", 1'b0);
      busStart();
      sendByte(8'hA1, "rr read ack", 1'b0);
      waitClk(HALF);
      pushExp("driving read bit", 8'd0);
      checkOutput({7'd0, (sda_bus === 1'b0) ? 1'b0 : 1'b1});
      reset_n = 0;
      #1;
      pushExp("sda on reset", 8'd1);
      checkOutput({7'd0, (sda_bus === 1'b0) ? 1'b0 : 1'b1});
      checkBusy(1'b0, "busy on reset");
      waitClk(HALF);
      scl = 1;
      waitClk(Q);
      reset_n = 1;
      waitClk(Q);
      busStart();
      sendByte(8'hA1, "post reset ack", 1'b0);
      recvByte(8'h33, "read from ptr 0", 1'b1);
      busStop();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2c_follower_eeprom.md
I2C_FOLLOWER_EEPROM -- requirements
Module: i2c_follower_eeprom

Interface
REQ-001 SHALL expose parameter DEV_ADDR, default 7'b1010000, 7-bit bus address the block answers to.
REQ-002 SHALL expose parameter PAGE_BITS, default 4, log2 of the write-page size (16 bytes).
REQ-003 SHALL have port CLK_50MHz, input, 1, system clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port RESET, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port SCL, input, 1, I2C clock from the leader.
REQ-006 SHALL have port SDA, inout, 1, open-drain data; driven only 1'b0 or 1'bz, never 1'b1.
REQ-007 SHALL have port WP, input, 1, write protect; 1 inhibits memory writes.
REQ-008 SHALL have port BUSY, output, 1, high from an addressed START until the next STOP/START or reset.
REQ-009 SHALL have port DBG_ADDR, input, 9, backdoor read address.
REQ-010 SHALL have port DBG_DATA, output, 8, mem[DBG_ADDR], combinational, for the bench.

Function
REQ-011 SHALL pass SCL and SDA through 2-flop synchronizers; all edge and START/STOP detection uses the synchronized copies.
REQ-012 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high, in every state.
REQ-013 SHALL hold 512x8 memory and a 9-bit address pointer PTR.
REQ-014 SHALL sample SDA on synchronized SCL rising edges and change its SDA drive only on the CLK cycle after a synchronized SCL falling edge is detected.
REQ-015 SHALL implement states IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WDATA, ACK_W, RDATA, RACK.
REQ-016 SHALL go IDLE->DEV on START and DEV->DEV on any START (repeated start) from any state, clearing the bit counter.
REQ-017 SHALL go to IDLE and release SDA on STOP from any state.
REQ-018 DEV SHALL shift 8 bits MSB-first; on address match it SHALL ACK by driving SDA low for the 9th SCL period, and otherwise it SHALL release SDA and return to IDLE until the next START.
REQ-019 When R/W=0 after a matched address, the block SHALL go ACK_DEV->AHI->ACK_AHI->ALO->ACK_ALO->WDATA; PTR = {AHI[0], ALO}; AHI[7:1] are ignored; every address byte SHALL be ACKed.
REQ-020 WDATA SHALL ACK each byte when WP=0, write mem[PTR] on the 8th SCL rise, and increment PTR[PAGE_BITS-1:0] only, wrapping inside the page.
REQ-021 WDATA with WP=1 SHALL NACK the byte (SDA released), leave memory and PTR unchanged, and remain in WDATA.
REQ-022 With R/W=1 the block SHALL enter RDATA after ACK_DEV and drive mem[PTR] MSB-first, releasing SDA for each 1 bit.
REQ-023 RACK SHALL release SDA and sample the leader bit; on 0 it SHALL set PTR=PTR+1 (511 wraps to 0) and continue in RDATA; on 1 it SHALL set PTR=PTR+1 and go IDLE.
REQ-024 The ACK/NACK drive SHALL span from the SCL fall after bit 8 to the SCL fall after bit 9.
REQ-025 SHALL operate correctly for SCL high and low phases each >= 8 CLK_50MHz cycles.
REQ-026 BUSY SHALL rise the cycle after a matched ACK_DEV entry and fall on STOP, on address mismatch or on reset.

Reset
REQ-027 While RESET=0: state IDLE, SDA released (z), BUSY=0, PTR=0, bit counter 0, synchronizers set to 1.
REQ-028 Assertion of RESET mid-transfer SHALL release SDA asynchronously, with no memory write for the partial byte.
REQ-029 Memory contents SHALL be unaffected by RESET; the power-up contents of memory are undefined.
REQ-030 After RESET deasserts, the block SHALL ignore bus activity until the first START.

Verification
REQ-031 Bench: START, 0xA0, 0x00, 0x05, 0x3C, STOP -> four ACKs, DBG_ADDR=5 gives DBG_DATA=0x3C, BUSY low after STOP.
REQ-032 Bench: START 0xA0 0x00 0x05, repeated START 0xA1, read one byte, leader NACK, STOP -> byte 0x3C, PTR=6.
REQ-033 Bench: write at address 0x0E the bytes 0x11,0x22,0x33 -> mem[0x0E]=0x11, mem[0x0F]=0x22, mem[0x00]=0x33, mem[0x10] unchanged.
REQ-034 Bench: START 0xA2 -> NACK, SDA never low until next START, BUSY stays 0.
REQ-035 Bench: WP=1, write 0x5A to address 0x005 -> address bytes ACKed, data NACKed, mem[5] remains 0x3C.
REQ-036 Bench: RESET low while driving a 0 read bit -> SDA z within the same cycle, BUSY=0, next START 0xA1 reads from PTR=0.
